mac_dot_seq: RTL and testbench

- Sequencer for the signed N-bit MAC datapath: accepts a dot-product job (length plus weight/activation base addresses) over a valid/ready handshake.
- Streams operand pairs from two synchronous-read operand buffers into the MAC, then returns the 2N-bit accumulator result over a valid/ready handshake.
- Sits between the job dispatcher and one MAC instance with synchronous clear; the MAC and the buffers are instantiated by the parent.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_dot_seq.sv | 103 ++++++++++
 tb/tb_mac_dot_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_pkg;

  localparam int MAC_N      = 18;
  localparam int MAC_LEN_W  = 10;
  localparam int MAC_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    FLUSH,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs from two buffers
// into an external MAC and returns the accumulator result.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int N      = MAC_N,
  parameter int LEN_W  = MAC_LEN_W,
  parameter int ADDR_W = MAC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [ADDR_W-1:0] start_w_base,
  input  logic [ADDR_W-1:0] start_x_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_w_addr,
  output logic [ADDR_W-1:0] rd_x_addr,
  input  logic [N-1:0]      rd_w_data,
  input  logic [N-1:0]      rd_x_data,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [N-1:0]      mac_w,
  output logic [N-1:0]      mac_x,
  input  logic [2*N-1:0]    mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*N-1:0]    res_data,
  output logic              busy
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  assign mac_w       = rd_w_data;
  assign mac_x       = rd_x_data;
  assign busy        = (state != IDLE);
  assign start_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      rd_en     <= 1'b0;
      rd_w_addr <= '0;
      rd_x_addr <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // read data lands one cycle after the strobe
      mac_en <= rd_en;
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            len_q     <= start_len;
            cnt       <= '0;
            rd_w_addr <= start_w_base;
            rd_x_addr <= start_x_base;
            mac_clr   <= 1'b1;
            rd_en     <= (start_len != '0);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mac_clr <= 1'b0;
          if (len_q == '0) begin
            state <= CAPTURE;
          end else if (cnt == len_q - 1'b1) begin
            rd_en <= 1'b0;
            state <= FLUSH;
          end else begin
            cnt       <= cnt + 1'b1;
            rd_w_addr <= rd_w_addr + 1'b1;
            rd_x_addr <= rd_x_addr + 1'b1;
          end
        end
        FLUSH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= mac_acc;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench: buffer and MAC models around the sequencer,
// dot products checked against a plain-arithmetic reference.
module tb_mac_dot_seq;

  localparam int N = 18;
  localparam int LEN_W = 10;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [LEN_W-1:0]  start_len;
  logic [ADDR_W-1:0] start_w_base;
  logic [ADDR_W-1:0] start_x_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_w_addr;
  logic [ADDR_W-1:0] rd_x_addr;
  logic [N-1:0]      rd_w_data;
  logic [N-1:0]      rd_x_data;
  logic              mac_clr;
  logic              mac_en;
  logic [N-1:0]      mac_w;
  logic [N-1:0]      mac_x;
  logic [2*N-1:0]    mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [2*N-1:0]    res_data;
  logic              busy;

  mac_dot_seq #(.N(N), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_len(start_len), .start_w_base(start_w_base),
    .start_x_base(start_x_base),
    .rd_en(rd_en), .rd_w_addr(rd_w_addr), .rd_x_addr(rd_x_addr),
    .rd_w_data(rd_w_data), .rd_x_data(rd_x_data),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_w(mac_w), .mac_x(mac_x), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic signed [N-1:0]   wmem [DEPTH];
  logic signed [N-1:0]   xmem [DEPTH];
  logic signed [2*N-1:0] acc;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_w_data <= wmem[rd_w_addr];
      rd_x_data <= xmem[rd_x_addr];
    end
  end

  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + $signed(mac_w) * $signed(mac_x);
  end
  assign mac_acc = acc;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] wb;
    logic [ADDR_W-1:0] xb;
    logic [1:0]        mode;
    logic [3:0][N-1:0] w;
    logic [3:0][N-1:0] x;
    logic [2:0]        hold;
    logic              use_exp;
    logic [2*N-1:0]    res_exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [2*N-1:0] ref_dot(int len, int wb, int xb);
    longint s = 0;
    for (int k = 0; k < len; k++)
      s += longint'(wmem[(wb + k) % DEPTH])
         * longint'(xmem[(xb + k) % DEPTH]);
    return s[2*N-1:0];
  endfunction

  function automatic vec_t mk(int len, int wb, int xb, int mode,
                              int hold, bit ue, logic [2*N-1:0] e);
    vec_t v = '0;
    v.len = LEN_W'(len);
    v.wb = ADDR_W'(wb);
    v.xb = ADDR_W'(xb);
    v.mode = 2'(mode);
    v.hold = 3'(hold);
    v.use_exp = ue;
    v.res_exp = e;
    return v;
  endfunction

  task automatic load(vec_t v);
    for (int k = 0; k < int'(v.len); k++) begin
      int wa = (int'(v.wb) + k) % DEPTH;
      int xa = (int'(v.xb) + k) % DEPTH;
      unique case (v.mode)
        2'd0: begin wmem[wa] = v.w[k]; xmem[xa] = v.x[k]; end
        2'd2: begin wmem[wa] = 18'h20000; xmem[xa] = 18'h20000; end
        default: begin
          wmem[wa] = N'($urandom);
          xmem[xa] = N'($urandom);
        end
      endcase
    end
  endtask

  task automatic run_job(vec_t v, string tag);
    int len = int'(v.len);
    int cyc = 0;
    int bad = 0;
    int bad2 = 0;
    logic [2*N-1:0] req;
    logic [2*N-1:0] held;
    load(v);
    req = v.use_exp ? v.res_exp : ref_dot(len, v.wb, v.xb);
    @(negedge clk);
    chk({tag, " idle_ready"}, {start_ready, busy}, 2'b10);
    start_valid = 1'b1;
    start_len = v.len;
    start_w_base = v.wb;
    start_x_base = v.xb;
    while (cyc <= len + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_valid = 1'b0;
        start_len = LEN_W'($urandom);
        start_w_base = ADDR_W'($urandom);
        start_x_base = ADDR_W'($urandom);
      end
      if (rd_en != (cyc >= 1 && cyc <= len)) bad++;
      if (cyc >= 1 && cyc <= len) begin
        if (rd_w_addr != ADDR_W'(int'(v.wb) + cyc - 1)) bad++;
        if (rd_x_addr != ADDR_W'(int'(v.xb) + cyc - 1)) bad++;
      end
      if (mac_clr != (cyc == 1)) bad++;
      if (mac_en != (cyc >= 2 && cyc <= len + 1)) bad++;
      if (!busy || start_ready) bad++;
      if (res_valid) break;
    end
    chk({tag, " latency"}, cyc, len + 3);
    chk({tag, " timing"}, bad, 0);
    chk({tag, " result"}, 64'(res_data), 64'(req));
    held = res_data;
    for (int h = 0; h < int'(v.hold); h++) begin
      start_valid = (h % 2 == 0);
      @(negedge clk);
      if (!res_valid || res_data != held || start_ready || !busy)
        bad2++;
    end
    start_valid = 1'b0;
    if (v.hold != 0) chk({tag, " hold"}, bad2, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " release"}, {res_valid, busy, start_ready}, 3'b001);
  endtask

  initial begin
    vecs[0] = mk(4, 0, 0, 0, 0, 1'b1, 36'd70);
    vecs[0].w = {18'd4, 18'd3, 18'd2, 18'd1};
    vecs[0].x = {18'd8, 18'd7, 18'd6, 18'd5};
    vecs[1] = mk(0, 7, 9, 1, 0, 1'b1, 36'd0);
    vecs[2] = mk(2, 100, 200, 0, 0, 1'b1,
                 36'(-64'sd17179738127));
    vecs[2].w = {18'd0, 18'd0, 18'h20000, 18'h3FFFD};
    vecs[2].x = {18'd0, 18'd0, 18'h1FFFF, 18'd5};
    vecs[3] = mk(4, 1022, 5, 1, 5, 1'b0, '0);
    vecs[4] = mk(12, 300, 600, 1, 0, 1'b0, '0);
    vecs[5] = mk(1023, 0, 512, 2, 0, 1'b1, 36'd51539607552);
    for (int i = 6; i < NV; i++)
      vecs[i] = mk(int'($urandom_range(0, 40)),
                   int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, DEPTH - 1)),
                   1, int'($urandom_range(0, 3)), 1'b0, '0);

    rst = 1'b1;
    start_valid = 1'b0;
    start_len = '0;
    start_w_base = '0;
    start_x_base = '0;
    res_ready = 1'b0;
    #3;
    chk("reset outs",
        {start_ready, rd_en, mac_clr, mac_en, res_valid, busy}, 0);
    chk("reset data", 64'(res_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready after reset", start_ready, 1);

    for (int i = 0; i < NV; i++)
      run_job(vecs[i], $sformatf("v%0d", i));

    // abandon a job mid-issue with an async reset
    @(negedge clk);
    start_valid = 1'b1;
    start_len = 10'd8;
    start_w_base = 10'd0;
    start_x_base = 10'd0;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("mid-job rd_en", rd_en, 1);
    rst = 1'b1;
    #1;
    chk("rst outs",
        {start_ready, rd_en, mac_clr, mac_en, res_valid, busy}, 0);
    chk("rst addr", {rd_w_addr, rd_x_addr}, 0);
    chk("rst data", 64'(res_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready", start_ready, 1);
    @(negedge clk);
    chk("rst no result", res_valid, 0);
    run_job(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
